timer0_compare_unit: RTL and testbench
======================================

// Module: timer0_compare_unit
// PURPOSE
//  Output-compare / waveform stage downstream of timer0_8bit. Consumes the live TCNT value and count tick.
//  Holds OCR0 (double-buffered in PWM modes) and detects compare match and overflow.
//  Drives OC0 per WGM/COM, raises OCF0/TOV0 and their interrupt requests, and issues the CTC clear to the timer.
// PARAMETERS
//  WIDTH     8     counter/compare width; MAX = all ones, BOTTOM = 0
//  OC_RESET  1'b0  reset value of OC0
// PORTS
//  sysClock     in   1      system clock; all state updates on rising edge
//  reset        in   1      asynchronous, active-high reset
//  count_tick   in   1      1-cycle pulse: timer advances TCNT at this edge
//  TCNT_value   in   WIDTH  current TCNT (value held during the tick)
//  count_dir    in   1      0 = up, 1 = down (phase-correct only; 0 otherwise)
//  TCCR_value   in   8      [7]FOC0 strobe, [6]WGM00, [5:4]COM0, [3]WGM01; [2:0] unused here
//  OCR_write    in   1      1-cycle write strobe for OCR0
//  OCR_input    in   WIDTH  OCR0 write data
//  flag_clear   in   2      write-1-to-clear: [1]OCF0, [0]TOV0
//  TIMSK_value  in   2      [1]OCIE0, [0]TOIE0
//  OCR_output   out  WIDTH  OCR0 as read by CPU (buffer register)
//  OC0          out  1      waveform output register
//  OC0_enable   out  1      1 when COM0 != 00 (pin owned by timer)
//  OCF0         out  1      compare-match flag
//  TOV0         out  1      overflow flag
//  ctc_clear    out  1      1-cycle active-high request to zero TCNT (CTC)
//  irq_compare  out  1      OCF0 & OCIE0 (combinational)
//  irq_overflow out  1      TOV0 & TOIE0 (combinational)
// BEHAVIOUR
//  - Reset: OCR buffer/active = 0, OC0 = OC_RESET, OCF0 = TOV0 = 0, ctc_clear = 0.
//  - Modes {WGM01,WGM00}: 00 normal, 01 phase-correct PWM, 10 CTC, 11 fast PWM.
//  - match = count_tick & (TCNT_value == OCR_active).
//  - All effects of a match register at the same edge; flags and OC0 are visible one cycle after the tick cycle.
//  - OCR: normal/CTC: write updates buffer and active at the same edge.
//    PWM modes: write updates buffer only; active <= buffer at a tick with TCNT_value == MAX.
//    A write and a match in the same cycle: compare uses the old active value.
//  - TOV0 set: normal/CTC/fast PWM on tick at MAX; phase-correct on tick at BOTTOM with count_dir = 1.
//  - OCF0 set on match in all modes.
//  - Flag set and flag_clear in the same cycle: set wins.
//  - ctc_clear: CTC only; a 1-cycle pulse on the edge following a match. In CTC, TCNT never reaches MAX unless OCR = MAX.
//  - COM, non-PWM: 00 hold, 01 toggle on match, 10 clear on match, 11 set on match.
//  - COM, fast PWM: 10 clear on match, set on tick at MAX; 11 inverted; 01 behaves as 00.
//    Tick at MAX with match: set (10) / clear (11) wins, so OCR = MAX gives constant high (10).
//  - COM, phase-correct: 10 clear on up-count match, set on down-count match; 11 inverted; 01 as 00.
//    OCR = 0 gives constant low; OCR = MAX gives constant high (10).
//  - FOC0 = 1 in normal/CTC: applies the COM action to OC0 at that edge. No OCF0, no ctc_clear.
//    FOC0 is ignored in PWM modes.
//  - WGM/COM change mid-count: takes effect on the next tick; OC0 holds its value.
//  - Reset mid-operation: immediate return to reset values; no pending pulse survives.
// STRUCTURE
//  - Shared header timer0_defs.vh: WGM_NORMAL/PHASE/CTC/FAST, COM_* encodings, TCCR bit indices.
//  - One sub-module, timer0_oc_waveform: COM/WGM/match/top/dir/FOC0 -> next OC0.
//  - OCR buffer, flags and ctc_clear live in the top module.
// TESTING
//  - CTC, OCR = 0x05, COM = 01, ticks from 0: match at TCNT = 5; ctc_clear pulses; OC0 toggles each period; OCF0 set; TOV0 stays 0.
//  - Fast PWM, OCR = 0x40, COM = 10: OC0 high after MAX tick, low after tick at 0x40.
//    OCR write 0x80 mid-period takes effect only after next MAX.
//  - Fast PWM, OCR = 0xFF, COM = 10: OC0 constantly 1. OCR = 0x00: 1-tick high pulse per period.
//  - Phase-correct, OCR = 0x10, COM = 10: low after up-count match at 0x10, high after down-count match; TOV0 at BOTTOM.
//  - Normal, TOV0 set at tick 0xFF with flag_clear[0] in the same cycle -> TOV0 = 1.
//    Clear alone -> 0. TOIE0 = 1 -> irq_overflow follows TOV0.
//  - FOC0 in normal, COM = 11 -> OC0 = 1, OCF0 unchanged. Reset asserted mid-PWM -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/timer0_compare_unit_pkg.sv
// Shared encodings for the timer0 output-compare stage: waveform modes,
// compare-output actions and TCCR bit positions.
package timer0_compare_unit_pkg;

  typedef enum logic [1:0] {
    WGM_NORMAL = 2'b00,
    WGM_PHASE  = 2'b01,
    WGM_CTC    = 2'b10,
    WGM_FAST   = 2'b11
  } wgm_e;

  typedef enum logic [1:0] {
    COM_DISCONNECT = 2'b00,
    COM_TOGGLE     = 2'b01,
    COM_CLEAR      = 2'b10,
    COM_SET        = 2'b11
  } com_e;

  localparam int TCCR_FOC0   = 7;
  localparam int TCCR_WGM00  = 6;
  localparam int TCCR_COM_HI = 5;
  localparam int TCCR_COM_LO = 4;
  localparam int TCCR_WGM01  = 3;

  // Both PWM modes have WGM00 set; they share OCR double-buffering.
  function automatic logic is_pwm(input wgm_e mode);
    return mode[0];
  endfunction

endpackage

// File: rtl/timer0_oc_waveform.sv
// Next-state logic for the OC0 waveform register, from the current mode,
// compare-output action and this cycle's match/top/direction events.
module timer0_oc_waveform
  import timer0_compare_unit_pkg::*;
(
  input  wgm_e wgm,
  input  com_e com,
  input  logic match,
  input  logic top,
  input  logic count_dir,
  input  logic foc,
  input  logic ocr_zero,
  input  logic ocr_max,
  input  logic oc_current,
  output logic oc_next
);

  logic phase_level;

  // COM 01 only has meaning in the non-PWM modes; PWM modes treat it as 00.
  always_comb begin
    oc_next     = oc_current;
    phase_level = count_dir;
    case (wgm)
      WGM_NORMAL, WGM_CTC: begin
        if (match || foc) begin
          case (com)
            COM_TOGGLE: oc_next = ~oc_current;
            COM_CLEAR:  oc_next = 1'b0;
            COM_SET:    oc_next = 1'b1;
            default:    oc_next = oc_current;
          endcase
        end
      end
      WGM_FAST: begin
        if (com == COM_CLEAR || com == COM_SET) begin
          if (top)
            oc_next = (com == COM_CLEAR);
          else if (match)
            oc_next = (com == COM_SET);
        end
      end
      WGM_PHASE: begin
        // Extremes pin the output so OCR=0/MAX give a flat waveform.
        if (ocr_zero)
          phase_level = 1'b0;
        else if (ocr_max)
          phase_level = 1'b1;
        if (match && (com == COM_CLEAR || com == COM_SET))
          oc_next = (com == COM_CLEAR) ? phase_level : ~phase_level;
      end
      default: oc_next = oc_current;
    endcase
  end

endmodule

// File: rtl/timer0_compare_unit.sv
// Output-compare stage for timer0: OCR0 buffering, compare/overflow flags,
// CTC clear request and the OC0 waveform register.
module timer0_compare_unit
  import timer0_compare_unit_pkg::*;
#(
  parameter int   WIDTH    = 8,
  parameter logic OC_RESET = 1'b0
) (
  input  logic             sysClock,
  input  logic             reset,
  input  logic             count_tick,
  input  logic [WIDTH-1:0] TCNT_value,
  input  logic             count_dir,
  input  logic [7:0]       TCCR_value,
  input  logic             OCR_write,
  input  logic [WIDTH-1:0] OCR_input,
  input  logic [1:0]       flag_clear,
  input  logic [1:0]       TIMSK_value,
  output logic [WIDTH-1:0] OCR_output,
  output logic             OC0,
  output logic             OC0_enable,
  output logic             OCF0,
  output logic             TOV0,
  output logic             ctc_clear,
  output logic             irq_compare,
  output logic             irq_overflow
);

  localparam logic [WIDTH-1:0] MAX_VALUE    = '1;
  localparam logic [WIDTH-1:0] BOTTOM_VALUE = '0;

  wgm_e             wgm;
  com_e             com;
  logic             pwm_mode;
  logic             match;
  logic             at_top;
  logic             tov_set;
  logic             oc_next;
  logic [WIDTH-1:0] ocr_buffer;
  logic [WIDTH-1:0] ocr_active;
  logic             unused_tccr;

  assign wgm         = wgm_e'({TCCR_value[TCCR_WGM01], TCCR_value[TCCR_WGM00]});
  assign com         = com_e'(TCCR_value[TCCR_COM_HI:TCCR_COM_LO]);
  assign pwm_mode    = is_pwm(wgm);
  assign unused_tccr = ^TCCR_value[2:0];

  assign match   = count_tick & (TCNT_value == ocr_active);
  assign at_top  = count_tick & (TCNT_value == MAX_VALUE);
  // Phase-correct overflows when the down-count reaches BOTTOM.
  assign tov_set = (wgm == WGM_PHASE)
                   ? (count_tick & count_dir & (TCNT_value == BOTTOM_VALUE))
                   : at_top;

  assign OCR_output   = ocr_buffer;
  assign OC0_enable   = (com != COM_DISCONNECT);
  assign irq_compare  = OCF0 & TIMSK_value[1];
  assign irq_overflow = TOV0 & TIMSK_value[0];

  timer0_oc_waveform u_waveform (
    .wgm        (wgm),
    .com        (com),
    .match      (match),
    .top        (at_top),
    .count_dir  (count_dir),
    .foc        (TCCR_value[TCCR_FOC0]),
    .ocr_zero   (ocr_active == BOTTOM_VALUE),
    .ocr_max    (ocr_active == MAX_VALUE),
    .oc_current (OC0),
    .oc_next    (oc_next)
  );

  // In PWM modes the active compare value only reloads at TOP, so a CPU
  // write mid-period cannot produce a glitched pulse.
  always_ff @(posedge sysClock or posedge reset) begin
    if (reset) begin
      ocr_buffer <= '0;
      ocr_active <= '0;
    end else begin
      if (OCR_write)
        ocr_buffer <= OCR_input;
      if (OCR_write && !pwm_mode)
        ocr_active <= OCR_input;
      else if (pwm_mode && at_top)
        ocr_active <= ocr_buffer;
    end
  end

  // Setting a flag takes priority over a simultaneous write-1-to-clear.
  always_ff @(posedge sysClock or posedge reset) begin
    if (reset) begin
      OCF0      <= 1'b0;
      TOV0      <= 1'b0;
      ctc_clear <= 1'b0;
      OC0       <= OC_RESET;
    end else begin
      OCF0      <= match | (OCF0 & ~flag_clear[1]);
      TOV0      <= tov_set | (TOV0 & ~flag_clear[0]);
      ctc_clear <= match & (wgm == WGM_CTC);
      OC0       <= oc_next;
    end
  end

endmodule

// File: tb/tb_timer0_compare_unit.sv
// Self-checking bench for timer0_compare_unit: directed mode scenarios plus
// randomized traffic against a rule-level reference model.
module tb_timer0_compare_unit;

  logic       sysClock = 1'b0;
  logic       reset;
  logic       count_tick;
  logic [7:0] TCNT_value;
  logic       count_dir;
  logic [7:0] TCCR_value;
  logic       OCR_write;
  logic [7:0] OCR_input;
  logic [1:0] flag_clear;
  logic [1:0] TIMSK_value;
  logic [7:0] OCR_output;
  logic       OC0, OC0_enable, OCF0, TOV0, ctc_clear, irq_compare, irq_overflow;

  logic [7:0] m_buf, m_act;
  bit         m_oc, m_ocf, m_tov, m_ctc;
  logic [7:0] tb_tcnt;
  bit         tb_dir;
  int         checks = 0;
  int         errors = 0;

  timer0_compare_unit dut (
    .sysClock     (sysClock),
    .reset        (reset),
    .count_tick   (count_tick),
    .TCNT_value   (TCNT_value),
    .count_dir    (count_dir),
    .TCCR_value   (TCCR_value),
    .OCR_write    (OCR_write),
    .OCR_input    (OCR_input),
    .flag_clear   (flag_clear),
    .TIMSK_value  (TIMSK_value),
    .OCR_output   (OCR_output),
    .OC0          (OC0),
    .OC0_enable   (OC0_enable),
    .OCF0         (OCF0),
    .TOV0         (TOV0),
    .ctc_clear    (ctc_clear),
    .irq_compare  (irq_compare),
    .irq_overflow (irq_overflow)
  );

  always #5 sysClock = ~sysClock;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic model_reset();
    m_buf = 8'h00; m_act = 8'h00;
    m_oc = 1'b0; m_ocf = 1'b0; m_tov = 1'b0; m_ctc = 1'b0;
  endtask

  // Reference behaviour: mode numbers 0 normal, 1 phase, 2 CTC, 3 fast.
  task automatic model_step();
    int mode, com;
    bit foc, pwm, is_match, at_max, tov_set, level;
    logic [7:0] old_buf;
    mode     = {TCCR_value[3], TCCR_value[6]};
    com      = TCCR_value[5:4];
    foc      = TCCR_value[7];
    pwm      = (mode == 1) || (mode == 3);
    is_match = count_tick && (TCNT_value == m_act);
    at_max   = count_tick && (TCNT_value == 8'hFF);
    old_buf  = m_buf;
    if (!pwm) begin
      if (is_match || foc) begin
        if (com == 1) m_oc = !m_oc;
        else if (com == 2) m_oc = 1'b0;
        else if (com == 3) m_oc = 1'b1;
      end
    end else if (mode == 3) begin
      if (com >= 2) begin
        if (at_max) m_oc = (com == 2);
        else if (is_match) m_oc = (com == 3);
      end
    end else if (is_match && com >= 2) begin
      if (m_act == 8'h00) level = 1'b0;
      else if (m_act == 8'hFF) level = 1'b1;
      else level = count_dir;
      m_oc = (com == 2) ? level : !level;
    end
    tov_set = (mode == 1) ? (count_tick && TCNT_value == 8'h00 && count_dir) : at_max;
    m_ocf = is_match ? 1'b1 : (flag_clear[1] ? 1'b0 : m_ocf);
    m_tov = tov_set  ? 1'b1 : (flag_clear[0] ? 1'b0 : m_tov);
    m_ctc = (mode == 2) && is_match;
    if (OCR_write) m_buf = OCR_input;
    if (OCR_write && !pwm) m_act = OCR_input;
    else if (pwm && at_max) m_act = old_buf;
  endtask

  task automatic compare_all();
    checkOutput("OC0", OC0, m_oc);
    checkOutput("OCF0", OCF0, m_ocf);
    checkOutput("TOV0", TOV0, m_tov);
    checkOutput("ctc_clear", ctc_clear, m_ctc);
    checkOutput("OCR_output", OCR_output, m_buf);
    checkOutput("OC0_enable", OC0_enable, TCCR_value[5:4] != 2'b00);
    checkOutput("irq_compare", irq_compare, m_ocf & TIMSK_value[1]);
    checkOutput("irq_overflow", irq_overflow, m_tov & TIMSK_value[0]);
  endtask

  task automatic applyStimulus();
    model_step();
    @(posedge sysClock);
    #1;
    compare_all();
    OCR_write     = 1'b0;
    flag_clear    = 2'b00;
    count_tick    = 1'b0;
    TCCR_value[7] = 1'b0;
  endtask

  // Emulates the upstream timer for one tick in the current mode.
  task automatic tick_once(output logic [7:0] ticked, output bit ticked_dir);
    int mode;
    mode       = {TCCR_value[3], TCCR_value[6]};
    count_tick = 1'b1;
    TCNT_value = tb_tcnt;
    count_dir  = (mode == 1) ? tb_dir : 1'b0;
    ticked     = tb_tcnt;
    ticked_dir = count_dir;
    if (mode == 1) begin
      if (!tb_dir) begin
        if (tb_tcnt == 8'hFF) begin tb_dir = 1'b1; tb_tcnt = 8'hFE; end
        else tb_tcnt = tb_tcnt + 8'd1;
      end else begin
        if (tb_tcnt == 8'h00) begin tb_dir = 1'b0; tb_tcnt = 8'h01; end
        else tb_tcnt = tb_tcnt - 8'd1;
      end
    end else if (mode == 2 && tb_tcnt == m_act) begin
      tb_tcnt = 8'h00;
    end else begin
      tb_tcnt = tb_tcnt + 8'd1;
    end
    applyStimulus();
  endtask

  initial begin
    logic [7:0] t;
    bit d, seen_bottom;
    int n_match;

    reset = 1'b1; count_tick = 1'b0; TCNT_value = 8'h00; count_dir = 1'b0;
    TCCR_value = 8'h00; OCR_write = 1'b0; OCR_input = 8'h00;
    flag_clear = 2'b00; TIMSK_value = 2'b00;
    #1;
    model_reset();
    compare_all();
    @(posedge sysClock); #3;
    reset = 1'b0;

    // CTC, OCR=5, toggle
    TCCR_value = 8'h18; OCR_write = 1'b1; OCR_input = 8'h05;
    applyStimulus();
    tb_tcnt = 8'h00; n_match = 0;
    for (int i = 0; i < 20; i++) begin
      tick_once(t, d);
      if (t == 8'h05) begin
        n_match++;
        checkOutput("ctc_pulse", ctc_clear, 1'b1);
        checkOutput("ctc_ocf", OCF0, 1'b1);
        checkOutput("ctc_toggle", OC0, n_match % 2);
      end else begin
        checkOutput("ctc_no_pulse", ctc_clear, 1'b0);
      end
      checkOutput("ctc_tov_low", TOV0, 1'b0);
    end

    // Normal: set wins over clear, then clear alone, overflow irq
    TCCR_value = 8'h00; TIMSK_value = 2'b01; flag_clear = 2'b11;
    applyStimulus();
    count_tick = 1'b1; TCNT_value = 8'hFF; flag_clear = 2'b01;
    applyStimulus();
    checkOutput("tov_set_wins", TOV0, 1'b1);
    checkOutput("irq_ovf_high", irq_overflow, 1'b1);
    flag_clear = 2'b01;
    applyStimulus();
    checkOutput("tov_cleared", TOV0, 1'b0);
    checkOutput("irq_ovf_low", irq_overflow, 1'b0);

    // Force compare in normal mode
    TCCR_value = 8'hA0; flag_clear = 2'b10;
    applyStimulus();
    checkOutput("foc_clear", OC0, 1'b0);
    TCCR_value = 8'hB0;
    applyStimulus();
    checkOutput("foc_set", OC0, 1'b1);
    checkOutput("foc_no_ocf", OCF0, 1'b0);
    checkOutput("foc_no_ctc", ctc_clear, 1'b0);

    // Fast PWM OCR=0x40, buffered write of 0x80 mid-period
    TCCR_value = 8'h00; OCR_write = 1'b1; OCR_input = 8'h40;
    applyStimulus();
    TCCR_value = 8'h68; tb_tcnt = 8'h00;
    for (int i = 0; i < 512; i++) begin
      if (i == 8'h20) begin OCR_write = 1'b1; OCR_input = 8'h80; end
      tick_once(t, d);
      if (i == 8'h20) checkOutput("fast_buf_read", OCR_output, 8'h80);
      if (t == 8'hFF) checkOutput("fast_top_set", OC0, 1'b1);
      if (t == 8'h40) checkOutput("fast_at_40", OC0, i < 256 ? 1'b0 : 1'b1);
      if (t == 8'h80) checkOutput("fast_at_80", OC0, 1'b0);
    end

    // Fast PWM OCR=MAX: constant high
    TCCR_value = 8'h00; OCR_write = 1'b1; OCR_input = 8'hFF;
    applyStimulus();
    TCCR_value = 8'h68;
    for (int i = 0; i < 256; i++) begin
      tick_once(t, d);
      checkOutput("fast_ff_high", OC0, 1'b1);
    end

    // Fast PWM OCR=0: one-tick high pulse per period
    TCCR_value = 8'h00; OCR_write = 1'b1; OCR_input = 8'h00;
    applyStimulus();
    TCCR_value = 8'h68;
    for (int i = 0; i < 512; i++) begin
      tick_once(t, d);
      checkOutput("fast_00_pulse", OC0, t == 8'hFF);
    end

    // Phase-correct OCR=0x10
    TCCR_value = 8'h00; OCR_write = 1'b1; OCR_input = 8'h10; flag_clear = 2'b11;
    applyStimulus();
    TCCR_value = 8'h60; tb_tcnt = 8'h00; tb_dir = 1'b0; seen_bottom = 1'b0;
    for (int i = 0; i < 1020; i++) begin
      tick_once(t, d);
      if (t == 8'h10) checkOutput("phase_match", OC0, d);
      if (t == 8'h00 && d) begin
        checkOutput("phase_tov", TOV0, 1'b1);
        seen_bottom = 1'b1;
      end else if (!seen_bottom) begin
        checkOutput("phase_no_tov", TOV0, 1'b0);
      end
    end

    // Randomized traffic across all modes
    for (int i = 0; i < 1500; i++) begin
      if (i % 100 == 0) begin
        TCCR_value  = 8'($urandom) & 8'h78;
        TIMSK_value = 2'($urandom);
      end
      count_tick = ($urandom_range(3) != 0);
      case ($urandom_range(3))
        0:       TCNT_value = m_act;
        1:       TCNT_value = 8'hFF;
        2:       TCNT_value = 8'h00;
        default: TCNT_value = 8'($urandom);
      endcase
      count_dir  = ({TCCR_value[3], TCCR_value[6]} == 2'b01) ? 1'($urandom) : 1'b0;
      OCR_write  = ($urandom_range(7) == 0);
      OCR_input  = 8'($urandom);
      flag_clear = ($urandom_range(3) == 0) ? 2'($urandom) : 2'b00;
      if ($urandom_range(15) == 0) TCCR_value[7] = 1'b1;
      applyStimulus();
    end

    // Asynchronous reset in the middle of fast PWM
    TCCR_value = 8'h68; tb_tcnt = 8'hF0;
    for (int i = 0; i < 40; i++) tick_once(t, d);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    compare_all();
    checkOutput("reset_oc0", OC0, 1'b0);
    @(posedge sysClock); #1;
    compare_all();
    reset = 1'b0;
    tick_once(t, d);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
